iterative_multdiv: RTL
======================

// Module: iterative_multdiv
// PURPOSE
//   Signed 32-bit sequential multiplier/divider for the processor's execute stage.
//   - One operation at a time, one radix-2 step per clock, driven by an internal 6-bit cycle counter.
//   - The counter saturates at 33.
//   - Accepts a one-cycle start pulse.
//   - Returns the result, an exception flag and a one-cycle ready pulse.
//   - The pipeline stalls on this block until ready.
// PARAMETERS
//   WIDTH   32  operand/result width; the counter width is clog2(WIDTH+2)
//   STEPS   32  iterations per operation; equals WIDTH
// PORTS
//   clock            in   1   single clock; everything updates on the rising edge
//   reset            in   1   asynchronous, active-low; 0 clears all state immediately
//   data_operandA    in   32  multiplicand / dividend, two's complement
//   data_operandB    in   32  multiplier / divisor, two's complement
//   ctrl_MULT        in   1   one-cycle start pulse for multiply
//   ctrl_DIV         in   1   one-cycle start pulse for divide
//   data_result      out  32  product low word / quotient
//   data_exception   out  1   overflow or divide-by-zero
//   data_resultRDY   out  1   one-cycle pulse: result and exception valid
// BEHAVIOUR
//   Reset (reset=0, async)
//     state=IDLE, count=0, data_result=0, data_exception=0, data_resultRDY=0.
//   FSM states: IDLE -> RUN -> DONE -> IDLE.
//   Start (edge E0, ctrl_MULT|ctrl_DIV=1)
//     - Latch |A|, |B|, the result sign and the op; count<=0; state<=RUN.
//     - If both ctrl bits are high, MULT wins.
//   RUN
//     - Each edge performs one step and increments count.
//     - MULT: shift-add on a 64-bit product register.
//     - DIV: restoring shift-subtract on a 32-bit remainder and quotient.
//     - At count==32 (after 32 steps), the next edge applies sign fix-up and exception logic.
//     - It then sets count<=33 (saturating; never wraps), state<=DONE and data_resultRDY<=1.
//   Latency and hold
//     - data_resultRDY is high during the cycle after edge E33: 33 edges after start.
//     - The next edge clears data_resultRDY and returns to IDLE.
//     - data_result and data_exception hold until the next start or reset.
//   MULT result and exception
//     - data_result = product[31:0].
//     - data_exception=1 when the signed 64-bit product is not the sign-extension of bit 31.
//   DIV result and exception
//     - Quotient truncates toward zero.
//     - B==0: result 0, exception 1.
//     - A=0x80000000, B=-1: result 0x80000000, exception 1.
//   Restart
//     - A start pulse in RUN or DONE aborts the current operation; no RDY is issued for it.
//     - The new operands are latched and count<=0, exactly as from IDLE.
//   Reset mid-operation
//     - Immediate abort to the reset values; no RDY pulse follows.
//   Start with reset=0: ignored.
// CONFIGURATION
//   MULTDIV_DIVZERO_FAST_EN defined
//     - DIV with B==0 at E0 skips RUN and goes straight to DONE.
//     - data_resultRDY=1 in the cycle after E0, with data_result=0 and data_exception=1.
//   MULTDIV_DIVZERO_FAST_EN undefined
//     - Divide-by-zero takes the full 33-edge latency, with the same result and exception.
//   All other behaviour is identical in both builds.
// TESTING
//   1. MULT A=6, B=7 -> RDY exactly 33 edges after start, result=42, exc=0; RDY low next cycle.
//   2. MULT A=-5, B=3 -> result=0xFFFFFFF1, exc=0.
//      MULT A=0x00010000, B=0x00010000 -> result=0, exc=1.
//   3. DIV A=100, B=7 -> result=14, exc=0.
//      DIV A=-100, B=7 -> result=0xFFFFFFF2 (-14).
//      DIV A=0x80000000, B=-1 -> result=0x80000000, exc=1.
//   4. DIV A=5, B=0 -> result=0, exc=1.
//      RDY after 33 edges without the macro; after 1 edge with MULTDIV_DIVZERO_FAST_EN.
//   5. Start MULT 3*4; at edge 10 pulse DIV 9/3.
//      -> exactly one RDY, 33 edges after the DIV pulse, result=3.
//      ctrl_MULT and ctrl_DIV together (A=2, B=2) -> result=4.
//   6. Drive reset=0 mid-RUN between edges.
//      -> outputs clear immediately, no RDY; after release a new MULT 2*2 -> result=4.

Source files
------------

// File: rtl/iterative_multdiv.sv
// Signed radix-2 sequential multiplier / restoring divider, one step per clock.
// Optional build macro MULTDIV_DIVZERO_FAST_EN: divide-by-zero completes in the cycle after start.
module iterative_multdiv #(
    parameter int WIDTH = 32,
    parameter int STEPS = WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] data_operandA,
    input  logic signed [WIDTH-1:0] data_operandB,
    input  logic                    ctrl_MULT,
    input  logic                    ctrl_DIV,
    output logic        [WIDTH-1:0] data_result,
    output logic                    data_exception,
    output logic                    data_resultRDY
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     op_q, op_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 exc_q, exc_d;
    logic                 rdy_q, rdy_d;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        mag = v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    logic             start, fast_dz, b_zero, steps_left;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign start      = ctrl_MULT | ctrl_DIV;
    assign b_zero     = (data_operandB == '0);
    assign a_mag      = mag(data_operandA);
    assign b_mag      = mag(data_operandB);
    assign steps_left = (cnt_q < CNT_W'(STEPS));
`ifdef MULTDIV_DIVZERO_FAST_EN
    assign fast_dz    = ctrl_DIV & ~ctrl_MULT & b_zero;
`else
    assign fast_dz    = 1'b0;
`endif

    // Multiply step: conditional add of multiplicand into the high half, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: shift remainder/quotient left, keep the subtraction only if it did not borrow.
    logic [WIDTH:0]     div_sh, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge   = (div_sh >= {1'b0, op_q});
    assign div_diff = div_sh - {1'b0, op_q};
    assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic               mul_exc, div_exc;
    assign prod_s  = neg_q ? -acc_q : acc_q;
    assign mul_exc = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
    assign quo_s   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // A non-negative quotient with the top bit set can only come from MIN / -1.
    assign div_exc = dz_q | (~neg_q & acc_q[WIDTH-1]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            op_q     <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = fast_dz ? DONE : RUN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     state_d = steps_left ? RUN : DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        op_d     = op_q;
        acc_d    = acc_q;
        res_d    = res_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        if (start) begin
            is_div_d = ~ctrl_MULT;
            neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_d     = ~ctrl_MULT & b_zero;
            op_d     = ctrl_MULT ? a_mag : b_mag;
            acc_d    = {{WIDTH{1'b0}}, (ctrl_MULT ? b_mag : a_mag)};
            cnt_d    = '0;
            if (fast_dz) begin
                res_d = '0;
                exc_d = 1'b1;
                rdy_d = 1'b1;
                cnt_d = CNT_W'(STEPS + 1);
            end
        end else if (state_q == RUN) begin
            if (steps_left) begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
            end else begin
                res_d = is_div_q ? (dz_q ? '0 : quo_s) : prod_s[WIDTH-1:0];
                exc_d = is_div_q ? div_exc : mul_exc;
                rdy_d = 1'b1;
                cnt_d = CNT_W'(STEPS + 1);
            end
        end
    end

    always_comb begin
        data_result    = res_q;
        data_exception = exc_q;
        data_resultRDY = rdy_q;
    end

endmodule
